// File: rtl/hello_ticker_reader_if.sv
// Bundle of the ticker character stream, counter clear, and the
// lock/count status returned by the HELLO ticker reader.
interface hello_ticker_reader_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic [2:0]       char_in;
  logic             clr_counts;
  logic             locked;
  logic             msg_done;
  logic             err;
  logic [2:0]       pos;
  logic [CNT_W-1:0] msg_count;
  logic [CNT_W-1:0] err_count;

  // Stream source / status consumer side.
  modport master (
    output tick, char_in, clr_counts,
    input  locked, msg_done, err, pos, msg_count, err_count
  );

  // Reader side.
  modport slave (
    input  tick, char_in, clr_counts,
    output locked, msg_done, err, pos, msg_count, err_count
  );
endinterface

// File: rtl/hello_ticker_reader.sv
// Receive-side checker for the HELLO ticker stream. Aligns to the
// 8-symbol frame H,E,L,L,O,_,_,_, locks after one clean frame, and
// keeps saturating counts of good frames and locked-state errors.
module hello_ticker_reader #(
  parameter int CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  hello_ticker_reader_if.slave  bus
);

  localparam logic [2:0] CH_H     = 3'b000;
  localparam logic [2:0] CH_E     = 3'b001;
  localparam logic [2:0] CH_L     = 3'b010;
  localparam logic [2:0] CH_O     = 3'b011;
  localparam logic [2:0] CH_BLANK = 3'b111;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [2:0]       pos_q, pos_n;
  logic             locked_q, locked_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_n;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_n;
  logic             msg_inc, err_inc;
  logic             is_h, match;

  // Symbol the frame expects at a given position.
  function automatic logic [2:0] expected_sym(input logic [2:0] p);
    case (p)
      3'd0:    expected_sym = CH_H;
      3'd1:    expected_sym = CH_E;
      3'd2,
      3'd3:    expected_sym = CH_L;
      3'd4:    expected_sym = CH_O;
      default: expected_sym = CH_BLANK;
    endcase
  endfunction

  // Illegal codes never appear in the table, so they always mismatch.
  assign is_h  = (bus.char_in == CH_H);
  assign match = (bus.char_in == expected_sym(pos_q));

  // Next-state, position and pulse decode for one accepted tick.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_n  = state;
    pos_n    = pos_q;
    locked_n = locked_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    msg_inc  = 1'b0;
    err_inc  = 1'b0;

    if (bus.tick) begin
      unique case (state)
        SEARCH: begin
          if (is_h) begin
            pos_n   = 3'd1;
            state_n = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            if (pos_q == 3'd7) begin
              pos_n    = 3'd0;
              locked_n = 1'b1;
              done_n   = 1'b1;
              msg_inc  = 1'b1;
              state_n  = LOCKED;
            end else begin
              pos_n = pos_q + 3'd1;
            end
          end else if (is_h) begin
            // A stray H may itself be the start of a new frame.
            pos_n = 3'd1;
          end else begin
            pos_n   = 3'd0;
            state_n = SEARCH;
          end
        end
        LOCKED: begin
          if (match) begin
            if (pos_q == 3'd7) begin
              pos_n   = 3'd0;
              done_n  = 1'b1;
              msg_inc = 1'b1;
            end else begin
              pos_n = pos_q + 3'd1;
            end
          end else begin
            err_n    = 1'b1;
            err_inc  = 1'b1;
            locked_n = 1'b0;
            if (is_h) begin
              pos_n   = 3'd1;
              state_n = VERIFY;
            end else begin
              pos_n   = 3'd0;
              state_n = SEARCH;
            end
          end
        end
        default: begin
          pos_n    = 3'd0;
          locked_n = 1'b0;
          state_n  = SEARCH;
        end
      endcase
    end
  end

  // Counter update: clear wins over an increment; increments stop at all-ones.
  always_comb begin
    msg_cnt_n = msg_cnt_q;
    err_cnt_n = err_cnt_q;
    if (bus.clr_counts) begin
      msg_cnt_n = '0;
      err_cnt_n = '0;
    end else begin
      if (msg_inc && (msg_cnt_q != CNT_MAX)) msg_cnt_n = msg_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != CNT_MAX)) err_cnt_n = err_cnt_q + 1'b1;
    end
  end

  // State and output registers, cleared immediately on reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= SEARCH;
      pos_q     <= 3'd0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state     <= state_n;
      pos_q     <= pos_n;
      locked_q  <= locked_n;
      done_q    <= done_n;
      err_q     <= err_n;
      msg_cnt_q <= msg_cnt_n;
      err_cnt_q <= err_cnt_n;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.msg_done  = done_q;
  assign bus.err       = err_q;
  assign bus.pos       = pos_q;
  assign bus.msg_count = msg_cnt_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_hello_ticker_reader.sv
// Scoreboard bench for hello_ticker_reader: each tick pushes the expected
// post-tick status; a monitor pops it one cycle later and compares.
module tb_hello_ticker_reader;

  localparam logic [2:0] H = 3'b000, E = 3'b001, L = 3'b010, O = 3'b011, B = 3'b111;

  logic clock;
  logic resetn;

  hello_ticker_reader_if #(.CNT_W(8)) bus ();
  hello_ticker_reader_if #(.CNT_W(2)) bus_s ();

  hello_ticker_reader #(.CNT_W(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  hello_ticker_reader #(.CNT_W(2)) dut_s (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_s.slave)
  );

  assign bus_s.tick       = bus.tick;
  assign bus_s.char_in    = bus.char_in;
  assign bus_s.clr_counts = bus.clr_counts;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       locked;
    logic       msg_done;
    logic       err;
    logic [2:0] pos;
    int         msg_count;
    int         err_count;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state (0 = SEARCH, 1 = VERIFY, 2 = LOCKED).
  int         m_state;
  logic [2:0] m_pos;
  logic       m_locked;
  int         m_msg;
  int         m_err;
  logic [2:0] sym [8];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_pos    = 3'd0;
    m_locked = 1'b0;
    m_msg    = 0;
    m_err    = 0;
  endtask

  // Drive one tick for a single cycle and push the expected response.
  task automatic send(input logic [2:0] c, input logic clr = 1'b0);
    exp_t e;
    logic m;
    e.msg_done = 1'b0;
    e.err      = 1'b0;
    m = (c == sym[m_pos]);
    case (m_state)
      0: if (c == H) begin m_pos = 3'd1; m_state = 1; end
      1: begin
        if (m && m_pos == 3'd7) begin
          m_pos = 3'd0; m_locked = 1'b1; e.msg_done = 1'b1; m_state = 2;
        end else if (m) m_pos = m_pos + 3'd1;
        else if (c == H) m_pos = 3'd1;
        else begin m_pos = 3'd0; m_state = 0; end
      end
      default: begin
        if (m && m_pos == 3'd7) begin
          m_pos = 3'd0; e.msg_done = 1'b1;
        end else if (m) m_pos = m_pos + 3'd1;
        else begin
          e.err = 1'b1; m_locked = 1'b0;
          if (c == H) begin m_pos = 3'd1; m_state = 1; end
          else begin m_pos = 3'd0; m_state = 0; end
        end
      end
    endcase
    if (e.msg_done && m_msg < 255) m_msg++;
    if (e.err && m_err < 255) m_err++;
    if (clr) begin m_msg = 0; m_err = 0; end
    e.locked    = m_locked;
    e.pos       = m_pos;
    e.msg_count = m_msg;
    e.err_count = m_err;
    exp_q.push_back(e);

    bus.tick       = 1'b1;
    bus.char_in    = c;
    bus.clr_counts = clr;
    @(posedge clock);
    #1;
    bus.tick       = 1'b0;
    bus.clr_counts = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.tick = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic frame(input logic clr_last = 1'b0);
    send(H); send(E); send(L); send(L); send(O); send(B); send(B); send(B, clr_last);
  endtask

  task automatic check_now(input string tag, input int lk, input int p, input int mc, input int ec);
    check({tag, ".locked"},    int'(bus.locked),    lk);
    check({tag, ".pos"},       int'(bus.pos),       p);
    check({tag, ".msg_count"}, int'(bus.msg_count), mc);
    check({tag, ".err_count"}, int'(bus.err_count), ec);
  endtask

  // Monitor: one cycle after each accepted tick, pop and compare; on
  // non-tick cycles the pulses must be low.
  initial begin
    logic t;
    exp_t e;
    forever begin
      @(posedge clock);
      t = bus.tick && resetn;
      #1;
      if (resetn) begin
        if (t) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb.locked",    int'(bus.locked),    int'(e.locked));
            check("sb.msg_done",  int'(bus.msg_done),  int'(e.msg_done));
            check("sb.err",       int'(bus.err),       int'(e.err));
            check("sb.pos",       int'(bus.pos),       int'(e.pos));
            check("sb.msg_count", int'(bus.msg_count), e.msg_count);
            check("sb.err_count", int'(bus.err_count), e.err_count);
          end
        end else begin
          check("idle.msg_done", int'(bus.msg_done), 0);
          check("idle.err",      int'(bus.err),      0);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    sym[0] = H; sym[1] = E; sym[2] = L; sym[3] = L;
    sym[4] = O; sym[5] = B; sym[6] = B; sym[7] = B;
    model_reset();
    resetn         = 1'b0;
    bus.tick       = 1'b0;
    bus.char_in    = 3'b000;
    bus.clr_counts = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.msg_done", int'(bus.msg_done), 0);
    check("rst.err",      int'(bus.err),      0);
    check_now("rst", 0, 0, 0, 0);
    resetn = 1'b1;
    idle(2);

    // Single frame with idle gaps between ticks.
    send(H); idle(2); send(E); idle(1); send(L); idle(3); send(L);
    idle(1); send(O); idle(2); send(B); idle(1); send(B); idle(4); send(B);
    idle(2);
    check_now("frame1", 1, 0, 1, 0);

    // Three back-to-back frames.
    frame(); frame(); frame();
    idle(1);
    check_now("b2b", 1, 0, 4, 0);

    // Locked, H then L: error, back to SEARCH; E ignored, then relock.
    send(H); send(L);
    idle(1);
    check_now("err_l", 0, 0, 4, 1);
    send(E);
    frame();
    idle(1);
    check_now("relock1", 1, 0, 5, 1);

    // Locked, H,E,L,H: error into VERIFY at pos 1; frame finishes from E.
    send(H); send(E); send(L); send(H);
    idle(1);
    check_now("err_h", 0, 1, 5, 2);
    send(E); send(L); send(L); send(O); send(B); send(B); send(B);
    idle(1);
    check_now("relock2", 1, 0, 6, 2);

    // Illegal code 101 at pos 5 while locked.
    send(H); send(E); send(L); send(L); send(O); send(3'b101);
    idle(1);
    check_now("illegal", 0, 0, 6, 3);

    // Relock, then reset asynchronously mid-frame at pos 4.
    frame();
    send(H); send(E); send(L); send(L);
    check_now("pre_rst", 1, 4, 7, 3);
    #2;
    resetn = 1'b0;
    #1;
    check_now("async_rst", 0, 0, 0, 0);
    check("async_rst.small_msg", int'(bus_s.msg_count), 0);
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    idle(1);

    // Five frames: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    repeat (5) frame();
    idle(1);
    check_now("five", 1, 0, 5, 0);
    check("sat.small_msg", int'(bus_s.msg_count), 3);
    check("sat.small_err", int'(bus_s.err_count), 0);

    // Clear coincident with the 8th tick: count 0 while msg_done still fires.
    frame(1'b1);
    idle(1);
    check_now("clr", 1, 0, 0, 0);
    frame();
    idle(3);
    check_now("after_clr", 1, 0, 1, 0);
    check("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
